// File: rtl/mnist_input_loader_if.sv
// Pixel-stream handshake and input-RAM write bus of the MNIST input loader.
// The loader sits on the slave modport; the pixel source and RAM observe via master.
interface mnist_input_loader_if #(
  parameter int ADDR_W = 10
);
  logic              PixelValid;
  logic [7:0]        Pixel;
  logic              PixelReady;
  logic              WrEn;
  logic [ADDR_W-1:0] WrAddr;
  logic [15:0]       WrData;

  modport master (
    output PixelValid, Pixel,
    input  PixelReady, WrEn, WrAddr, WrData
  );

  modport slave (
    input  PixelValid, Pixel,
    output PixelReady, WrEn, WrAddr, WrData
  );
endinterface

// File: rtl/mnist_input_loader.sv
// Writer side of the network input-image RAM: converts 8-bit pixels to 16-bit fixed point.
// Define MNIST_INPUT_LOADER_THRESHOLD_EN to binarize pixels (>=128 -> 2048) instead of Pixel*8.
//
// state | meaning
// IDLE  | waiting for Start, pixel counter held at 0
// LOAD  | accepting pixels, one RAM write per accept
// FLUSH | final write retiring
// FIRE  | one-cycle Compute pulse to the inference core
// WAIT  | waiting for a 0->1 edge on NetR, then Done
module mnist_input_loader #(
  parameter int N_PIXELS  = 784,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W    = 10
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Abort,
  mnist_input_loader_if.slave  bus,
  output logic                 Compute,
  input  logic                 NetR,
  output logic                 Busy,
  output logic                 Done
);

  localparam int CNT_W = $clog2(N_PIXELS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_PIXELS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    FIRE,
    WAIT
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              netr_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [15:0]       wr_data_q;

  logic              accept;
  logic              netr_rise;
  logic              cancel;
  logic [15:0]       pixel_fx_d;
  logic [ADDR_W-1:0] wr_addr_d;

  assign accept    = (state_q == LOAD) && bus.PixelValid;
  assign netr_rise = NetR && !netr_q;
  assign cancel    = Abort || Reset;
  assign wr_addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(cnt_q);

`ifdef MNIST_INPUT_LOADER_THRESHOLD_EN
  assign pixel_fx_d = (bus.Pixel >= 8'd128) ? 16'd2048 : 16'd0;
`else
  assign pixel_fx_d = {5'b0, bus.Pixel, 3'b0};
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      netr_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= ADDR_W'(BASE_ADDR);
      wr_data_q <= '0;
    end else begin
      netr_q  <= NetR;
      wr_en_q <= accept;
      if (accept) begin
        wr_addr_q <= wr_addr_d;
        wr_data_q <= pixel_fx_d;
      end
      // Abort overrides every transition, including the last accept and the NetR edge.
      if (Abort && (state_q != IDLE)) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            cnt_q <= '0;
            if (Start) state_q <= LOAD;
          end
          LOAD: begin
            if (accept) begin
              cnt_q <= cnt_q + 1'b1;
              if (cnt_q == LAST_CNT) state_q <= FLUSH;
            end
          end
          FLUSH:   state_q <= FIRE;
          FIRE:    state_q <= WAIT;
          WAIT:    if (netr_rise) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.PixelReady = (state_q == LOAD);
  assign bus.WrEn       = wr_en_q;
  assign bus.WrAddr     = wr_addr_q;
  assign bus.WrData     = wr_data_q;
  assign Busy           = (state_q != IDLE);
  // Pulses are suppressed in the same cycle an abort or reset arrives.
  assign Compute        = (state_q == FIRE) && !cancel;
  assign Done           = (state_q == WAIT) && netr_rise && !cancel;

endmodule

// File: tb/tb_mnist_input_loader.sv
// Self-checking bench for mnist_input_loader: random pixel streams against a
// frame-level reference model, plus directed abort/ignore/threshold scenarios.
module tb_mnist_input_loader;
  localparam int N_PIXELS  = 784;
  localparam int BASE_ADDR = 0;
  localparam int ADDR_W    = 10;

  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_FLUSH = 2;
  localparam int P_FIRE  = 3;
  localparam int P_WAIT  = 4;

  logic Clk = 1'b0;
  logic Reset, Start, Abort, NetR;
  logic Compute, Busy, Done;
  logic pv;
  logic [7:0] px;

  mnist_input_loader_if #(.ADDR_W(ADDR_W)) bus ();
  assign bus.PixelValid = pv;
  assign bus.Pixel      = px;

  mnist_input_loader #(
    .N_PIXELS (N_PIXELS),
    .BASE_ADDR(BASE_ADDR),
    .ADDR_W   (ADDR_W)
  ) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Start  (Start),
    .Abort  (Abort),
    .bus    (bus),
    .Compute(Compute),
    .NetR   (NetR),
    .Busy   (Busy),
    .Done   (Done)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // reference model
  int m_phase, m_cnt, m_addr, m_data, n_acc, last_acc_cyc;
  bit m_wr, m_netr_prev;
  // observations of the DUT
  int n_wr, n_comp, n_done, first_addr, last_addr, comp_cyc, done_cyc, cyc, rise_cyc;
  int wr_log[$];

  function automatic int conv(input int p);
`ifdef MNIST_INPUT_LOADER_THRESHOLD_EN
    return (p >= 128) ? 2048 : 0;
`else
    return p * 8;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_wr = 0; n_comp = 0; n_done = 0; n_acc = 0;
    first_addr = -1; last_addr = -1; comp_cyc = -1; done_cyc = -1; last_acc_cyc = -1;
    wr_log.delete();
  endtask

  task automatic tick();
    bit acc, rise, quiet;
    @(negedge Clk);
    acc   = (m_phase == P_LOAD) && (pv == 1'b1);
    rise  = (NetR == 1'b1) && !m_netr_prev;
    quiet = (Abort == 1'b1) || (Reset == 1'b1);
    chk("PixelReady", 32'(bus.PixelReady), 32'(m_phase == P_LOAD));
    chk("Busy", 32'(Busy), 32'(m_phase != P_IDLE));
    chk("WrEn", 32'(bus.WrEn), 32'(m_wr));
    if (m_wr) begin
      chk("WrAddr", 32'(bus.WrAddr), 32'(m_addr));
      chk("WrData", 32'(bus.WrData), 32'(m_data));
    end
    chk("Compute", 32'(Compute), 32'((m_phase == P_FIRE) && !quiet));
    chk("Done", 32'(Done), 32'((m_phase == P_WAIT) && rise && !quiet));
    if (bus.WrEn === 1'b1) begin
      if (n_wr > 0) chk("WrAddr_contig", 32'(bus.WrAddr), 32'(last_addr + 1));
      else first_addr = int'(bus.WrAddr);
      last_addr = int'(bus.WrAddr);
      wr_log.push_back(int'(bus.WrData));
      n_wr++;
    end
    if (Compute === 1'b1) begin n_comp++; comp_cyc = cyc; end
    if (Done === 1'b1) begin n_done++; done_cyc = cyc; end
    if (Reset) begin
      m_phase = P_IDLE; m_cnt = 0; m_netr_prev = 0; m_wr = 0;
    end else begin
      m_wr = acc;
      if (acc) begin
        m_addr = (BASE_ADDR + m_cnt) % (1 << ADDR_W);
        m_data = conv(int'(px));
        n_acc++;
        last_acc_cyc = cyc;
      end
      if (Abort && m_phase != P_IDLE) begin
        m_phase = P_IDLE; m_cnt = 0;
      end else begin
        case (m_phase)
          P_IDLE:  begin m_cnt = 0; if (Start) m_phase = P_LOAD; end
          P_LOAD:  if (acc) begin m_cnt++; if (m_cnt == N_PIXELS) m_phase = P_FLUSH; end
          P_FLUSH: m_phase = P_FIRE;
          P_FIRE:  m_phase = P_WAIT;
          P_WAIT:  if (rise) m_phase = P_IDLE;
          default: m_phase = P_IDLE;
        endcase
      end
      m_netr_prev = NetR;
    end
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic wait_compute();
    for (int k = 0; k < 10 && n_comp == 0; k++) tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1; Start = 0; Abort = 0; NetR = 0; pv = 0; px = 0;
    m_phase = P_IDLE; m_cnt = 0; m_wr = 0; m_netr_prev = 0; m_addr = 0; m_data = 0; cyc = 0;
    clr();
    repeat (3) tick();
    Reset = 0;
    chk("rst_WrAddr", 32'(bus.WrAddr), 32'(BASE_ADDR));
    chk("rst_WrData", 32'(bus.WrData), 32'd0);
    chk("rst_Busy", 32'(Busy), 32'd0);

    // PixelValid in IDLE is ignored
    pv = 1; px = 8'd77;
    repeat (4) tick();
    pv = 0;
    chk("idle_no_write", 32'(n_wr), 32'd0);

    // full-rate frame, p[i] = i mod 256, with a stray Start during LOAD and WAIT
    clr();
    Start = 1; tick(); Start = 0;
    pv = 1;
    for (int i = 0; i < N_PIXELS; i++) begin
      px = 8'(i % 256);
      Start = (i == 100);
      tick();
    end
    Start = 0; pv = 0;
    wait_compute();
    chk("full_writes", 32'(n_wr), 32'(N_PIXELS));
    chk("full_first_addr", 32'(first_addr), 32'(BASE_ADDR));
    chk("full_last_addr", 32'(last_addr), 32'(BASE_ADDR + N_PIXELS - 1));
    chk("full_last_data", 32'(wr_log[N_PIXELS-1]), 32'(conv((N_PIXELS - 1) % 256)));
    chk("full_compute_count", 32'(n_comp), 32'd1);
    chk("full_compute_lat", 32'(comp_cyc - last_acc_cyc), 32'd2);
    for (int k = 0; k < 49; k++) begin
      Start = (k == 20);
      tick();
    end
    Start = 0;
    NetR = 1; rise_cyc = cyc; tick();
    chk("full_done_count", 32'(n_done), 32'd1);
    chk("full_done_cycle", 32'(done_cyc), 32'(rise_cyc));
    chk("full_busy_after_done", 32'(Busy), 32'd0);
    NetR = 0; tick();

    // random backpressure, random pixels
    clr();
    Start = 1; tick(); Start = 0;
    for (int k = 0; k < 20000 && n_acc < N_PIXELS; k++) begin
      pv = 1'($urandom);
      px = 8'($urandom);
      tick();
    end
    pv = 1;
    tick();
    chk("bp_ready_low", 32'(bus.PixelReady), 32'd0);
    pv = 0;
    wait_compute();
    chk("bp_writes", 32'(n_wr), 32'(N_PIXELS));
    chk("bp_last_addr", 32'(last_addr), 32'(BASE_ADDR + N_PIXELS - 1));
    chk("bp_compute_count", 32'(n_comp), 32'd1);
    NetR = 1; tick(); NetR = 0; tick();
    chk("bp_done_count", 32'(n_done), 32'd1);

    // NetR held high through FIRE and WAIT
    clr();
    NetR = 1;
    Start = 1; tick(); Start = 0;
    pv = 1;
    for (int i = 0; i < N_PIXELS; i++) begin px = 8'($urandom); tick(); end
    pv = 0;
    repeat (20) tick();
    chk("level_compute", 32'(n_comp), 32'd1);
    chk("level_no_done", 32'(n_done), 32'd0);
    NetR = 0; tick();
    NetR = 1; tick();
    chk("level_edge_done", 32'(n_done), 32'd1);
    NetR = 0; tick();

    // abort after 300 accepts, then restart
    clr();
    Start = 1; tick(); Start = 0;
    pv = 1;
    for (int k = 0; k < 2000 && n_acc < 300; k++) begin px = 8'($urandom); tick(); end
    pv = 0; Abort = 1; tick(); Abort = 0;
    chk("abort_busy", 32'(Busy), 32'd0);
    repeat (5) tick();
    chk("abort_writes", 32'(n_wr), 32'd300);
    chk("abort_no_compute", 32'(n_comp), 32'd0);
    clr();
    Start = 1; tick(); Start = 0;
    pv = 1; px = 8'd9;
    repeat (5) tick();
    pv = 0; tick();
    chk("restart_addr", 32'(first_addr), 32'(BASE_ADDR));
    Abort = 1; tick(); Abort = 0; tick();

    // pixels 127/128/255, then Abort coincident with the NetR edge in WAIT
    clr();
    Start = 1; tick(); Start = 0;
    pv = 1;
    for (int i = 0; i < N_PIXELS; i++) begin
      px = (i == 0) ? 8'd127 : (i == 1) ? 8'd128 : (i == 2) ? 8'd255 : 8'($urandom);
      tick();
    end
    pv = 0;
    wait_compute();
    repeat (3) tick();
`ifdef MNIST_INPUT_LOADER_THRESHOLD_EN
    chk("thr_127", 32'(wr_log[0]), 32'd0);
    chk("thr_128", 32'(wr_log[1]), 32'd2048);
    chk("thr_255", 32'(wr_log[2]), 32'd2048);
`else
    chk("lin_127", 32'(wr_log[0]), 32'd1016);
    chk("lin_128", 32'(wr_log[1]), 32'd1024);
    chk("lin_255", 32'(wr_log[2]), 32'd2040);
`endif
    NetR = 1; Abort = 1; tick(); Abort = 0; NetR = 0;
    chk("abort_wait_no_done", 32'(n_done), 32'd0);
    chk("abort_wait_busy", 32'(Busy), 32'd0);
    tick();

    // reset in the middle of a frame
    clr();
    Start = 1; tick(); Start = 0;
    pv = 1;
    for (int i = 0; i < 10; i++) begin px = 8'($urandom); tick(); end
    Reset = 1; tick(); Reset = 0; pv = 0;
    chk("midrst_WrEn", 32'(bus.WrEn), 32'd0);
    chk("midrst_WrAddr", 32'(bus.WrAddr), 32'(BASE_ADDR));
    chk("midrst_WrData", 32'(bus.WrData), 32'd0);
    chk("midrst_Busy", 32'(Busy), 32'd0);
    repeat (3) tick();
    chk("midrst_no_pulse", 32'(n_comp + n_done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
